// File: rtl/bit_serial_alu_ctrl.sv
// bit_serial_alu_ctrl
//   Sequences one external 1-bit ALU slice over WIDTH cycles, LSB first, to
//   perform an N-bit AND/OR/ADD/SUB/NOR. The operands are latched on an
//   accepted start. The carry ripples through a register. The result and
//   flags are assembled here, and done pulses for one cycle at the end.
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   start, alu_op, a, b : request; sampled only while ready
//   ready/busy/done     : IDLE / RUN / DONE state decode
//   err                 : last accepted start carried an invalid alu_op
//   result, carry_out, overflow, zero : held until the next accepted start
//   slice_*             : drive to / return from the shared 1-bit slice
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             slice_in1,
  output logic             slice_in2,
  output logic             slice_cin,
  output logic             slice_ainv,
  output logic             slice_binv,
  output logic [1:0]       slice_op,
  input  logic             slice_result,
  input  logic             slice_cout
);
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q, b_q, result_q, result_d;
  logic [2:0]       op_q;
  logic             carry_q, cout_q, ovf_q, zero_q, err_q;
  logic             run, arith;

  assign run   = (state_q == RUN);
  assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);

  // The result with the current slice bit merged in. The zero flag is taken
  // from this value so the final bit is included.
  always_comb begin
    result_d        = result_q;
    result_d[idx_q] = slice_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          result_q <= '0;
          cout_q   <= 1'b0;
          ovf_q    <= 1'b0;
          zero_q   <= 1'b0;
          if (alu_op <= OP_NOR) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= alu_op;
            idx_q   <= '0;
            // SUB is a + ~b + 1: the +1 enters as the initial carry.
            carry_q <= (alu_op == OP_SUB);
            err_q   <= 1'b0;
            state_q <= RUN;
          end else begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        RUN: begin
          result_q <= result_d;
          carry_q  <= slice_cout;
          if (idx_q == LAST) begin
            cout_q  <= arith & slice_cout;
            // carry_q holds the carry into the MSB at this point.
            ovf_q   <= arith & (carry_q ^ slice_cout);
            zero_q  <= (result_d == '0);
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign busy      = run;
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  // The slice controls are forced low outside RUN.
  assign slice_in1  = run & a_q[idx_q];
  assign slice_in2  = run & b_q[idx_q];
  assign slice_cin  = run & carry_q;
  assign slice_ainv = run & (op_q == OP_NOR);
  assign slice_binv = run & ((op_q == OP_SUB) || (op_q == OP_NOR));
  assign slice_op   = !run                         ? 2'b00 :
                      (op_q == OP_OR)              ? 2'b01 :
                      arith                        ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Bench for bit_serial_alu_ctrl. A behavioural 1-bit slice closes the loop.
// Results are checked against a whole-word arithmetic reference model.
module tb_bit_serial_alu_ctrl;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] alu_op;
  logic [7:0] a, b, result;
  logic       ready, busy, done, err, carry_out, overflow, zero;
  logic       slice_in1, slice_in2, slice_cin, slice_ainv, slice_binv;
  logic [1:0] slice_op;
  logic       slice_result, slice_cout;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  bit_serial_alu_ctrl #(.WIDTH(8), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .err(err), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero),
    .slice_in1(slice_in1), .slice_in2(slice_in2), .slice_cin(slice_cin),
    .slice_ainv(slice_ainv), .slice_binv(slice_binv), .slice_op(slice_op),
    .slice_result(slice_result), .slice_cout(slice_cout));

  // External 1-bit ALU slice.
  logic sa, sb;
  always_comb begin
    sa = slice_in1 ^ slice_ainv;
    sb = slice_in2 ^ slice_binv;
    case (slice_op)
      2'b00:   slice_result = sa & sb;
      2'b01:   slice_result = sa | sb;
      2'b10:   slice_result = sa ^ sb ^ slice_cin;
      default: slice_result = 1'b0;
    endcase
    slice_cout = (sa & sb) | (sa & slice_cin) | (sb & slice_cin);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {logic [7:0] r; logic c, v, z, e;} exp_t;

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    logic [8:0] s;
    e = '0;
    case (op)
      3'd0: e.r = x & y;
      3'd1: e.r = x | y;
      3'd2: begin
        s = {1'b0, x} + {1'b0, y};
        e.r = s[7:0]; e.c = s[8];
        e.v = (x[7] == y[7]) && (e.r[7] != x[7]);
      end
      3'd3: begin
        s = {1'b0, x} + {1'b0, ~y} + 9'd1;
        e.r = s[7:0]; e.c = s[8];
        e.v = (x[7] != y[7]) && (e.r[7] != x[7]);
      end
      3'd4: e.r = ~(x | y);
      default: e.e = 1'b1;
    endcase
    if (!e.e) e.z = (e.r == 8'h00);
    return e;
  endfunction

  task automatic chk_slice_idle();
    chk("slice_idle", {slice_in1, slice_in2, slice_cin, slice_ainv, slice_binv, slice_op}, 0);
  endtask

  // Issues one request and checks latency, the outputs, and the single done pulse.
  // With poke set, start is re-pulsed during RUN with fresh operands.
  task automatic do_op(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y, input bit poke);
    exp_t e;
    int n;
    e = model(op, x, y);
    chk("ready_idle", ready, 1);
    chk_slice_idle();
    start = 1'b1; alu_op = op; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); alu_op = 3'($urandom);
    n = 1;
    if (!e.e) chk("busy_run", {busy, ready}, 2'b10);
    while (!done && n < 40) begin
      if (poke && n == 3) begin
        start = 1'b1; a = 8'($urandom); b = 8'($urandom); alu_op = 3'd2;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk($sformatf("latency op%0d", op), n, e.e ? 1 : 9);
    chk($sformatf("result op%0d %h,%h", op, x, y), result, e.r);
    chk("flags", {carry_out, overflow, zero, err}, {e.c, e.v, e.z, e.e});
    @(posedge clk); #1;
    chk("done_single", {done, ready}, 2'b01);
    repeat (2) @(posedge clk);
    #1;
    chk("hold", {done, result, carry_out, overflow, zero, err}, {1'b0, e.r, e.c, e.v, e.z, e.e});
  endtask

  initial begin
    int dcnt;
    rst = 1'b1; start = 1'b0; alu_op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {ready, busy, done, err, result, carry_out, overflow, zero}, {1'b1, 3'b000, 8'h00, 3'b000});
    chk_slice_idle();
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(3'd2, 8'h5A, 8'h3C, 0);
    do_op(3'd3, 8'h10, 8'h01, 0);
    do_op(3'd3, 8'h80, 8'h01, 0);
    do_op(3'd2, 8'hFF, 8'h01, 0);
    do_op(3'd4, 8'hF0, 8'h0C, 0);
    do_op(3'd0, 8'hF0, 8'h3C, 0);
    do_op(3'd1, 8'hF0, 8'h0C, 0);
    do_op(3'd2, 8'h12, 8'h34, 1);
    do_op(3'd7, 8'hAA, 8'h55, 0);
    do_op(3'd2, 8'h01, 8'h02, 0);

    // Reset while RUN is at idx 3 aborts the operation without a done pulse.
    start = 1'b1; alu_op = 3'd2; a = 8'h5A; b = 8'h3C;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_run_bit3", {busy, slice_in1, slice_in2}, 3'b111);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_abort", {ready, busy, done, err, result, carry_out, overflow, zero}, {1'b1, 3'b000, 8'h00, 3'b000});
    chk_slice_idle();
    dcnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("no_done_after_rst", dcnt, 0);

    for (int i = 0; i < 40; i++)
      do_op((i % 8 == 7) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
            8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
